// File: rtl/nip_window_former_if.sv
// Bus bundle for nip_window_former: row-buffer read beats in, 3x3 windows and status out.
interface nip_window_former_if #(
   parameter int PIX_W   = 8,
   parameter int NUM_RB  = 4,
   parameter int STEER_W = 2
);
   logic [NUM_RB*PIX_W-1:0] rb_data;
   logic [STEER_W-1:0]      steer;
   logic                    steer_en;
   logic                    in_ready;
   logic [9*PIX_W-1:0]      win;
   logic                    win_valid;
   logic                    row_done;
   logic                    frame_done;
   logic                    drop_err;

   modport master (
      output rb_data, steer, steer_en,
      input  in_ready, win, win_valid, row_done, frame_done, drop_err
   );

   modport slave (
      input  rb_data, steer, steer_en,
      output in_ready, win, win_valid, row_done, frame_done, drop_err
   );
endinterface

// File: rtl/nip_window_former.sv
// Restores image row order from the row-buffer read port and shifts columns into 3x3 windows.
// Define NIP_BORDER_ZERO_EN for horizontal zero padding (IMG_W windows per output row).
module nip_window_former #(
   parameter int PIX_W   = 8,
   parameter int IMG_W   = 64,
   parameter int IMG_H   = 64,
   parameter int NUM_RB  = 4,
   parameter int STEER_W = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   nip_window_former_if.slave bus
);
   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = (IMG_H > 3) ? $clog2(IMG_H - 2) : 1;
   localparam int WIN_W = 9 * PIX_W;
   localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 3);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FILL   = 3'd1,
      S_STREAM = 3'd2,
      S_FLUSH  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t             state_r;
   state_t             state_nx_s;
   logic [COL_W-1:0]   col_r;
   logic [ROW_W-1:0]   orow_r;
   logic [WIN_W-1:0]   sh_r;
   logic [WIN_W-1:0]   sh_shift_s;
   logic [WIN_W-1:0]   win_r;
   logic               in_ready_r;
   logic               win_valid_r;
   logic               row_done_r;
   logic               frame_done_r;
   logic               drop_err_r;
   logic               accept_s;
   logic               drop_s;
   logic               emit_s;
   logic               row_end_s;
   logic               frame_end_s;
   logic               flush_s;
   logic               clr_sh_s;
   logic               col_adv_s;
   logic               orow_adv_s;
   logic               orow_clr_s;
   logic [PIX_W-1:0]   rb_arr_s [NUM_RB];
   logic [STEER_W-1:0] top_idx_s;
   logic [STEER_W-1:0] mid_idx_s;
   logic [STEER_W-1:0] bot_idx_s;

   function automatic logic [WIN_W-1:0] shift_col(
      input logic [WIN_W-1:0] cur,
      input logic [PIX_W-1:0] top,
      input logic [PIX_W-1:0] mid,
      input logic [PIX_W-1:0] bot
   );
      logic [WIN_W-1:0] nx;
      nx = cur;
      for (int r = 0; r < 3; r++) begin
         nx[(r*3+0)*PIX_W +: PIX_W] = cur[(r*3+1)*PIX_W +: PIX_W];
         nx[(r*3+1)*PIX_W +: PIX_W] = cur[(r*3+2)*PIX_W +: PIX_W];
      end
      nx[2*PIX_W +: PIX_W] = top;
      nx[5*PIX_W +: PIX_W] = mid;
      nx[8*PIX_W +: PIX_W] = bot;
      return nx;
   endfunction

   for (genvar g = 0; g < NUM_RB; g++) begin : g_rb
      assign rb_arr_s[g] = bus.rb_data[g*PIX_W +: PIX_W];
   end

   // The buffer after the one being written is the oldest row, i.e. the window's top row.
   assign top_idx_s = bus.steer + STEER_W'(1);
   assign mid_idx_s = bus.steer + STEER_W'(2);
   assign bot_idx_s = bus.steer + STEER_W'(3);

   assign sh_shift_s = flush_s ? shift_col(sh_r, {PIX_W{1'b0}}, {PIX_W{1'b0}}, {PIX_W{1'b0}})
                               : shift_col(sh_r, rb_arr_s[top_idx_s], rb_arr_s[mid_idx_s],
                                           rb_arr_s[bot_idx_s]);

   assign accept_s = bus.steer_en & in_ready_r;
   assign drop_s   = bus.steer_en & ~in_ready_r;

   // State register; start returns to idle ahead of any beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
      end else if (start) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state and datapath control decode.
   always_comb begin
      state_nx_s  = state_r;
      emit_s      = 1'b0;
      row_end_s   = 1'b0;
      frame_end_s = 1'b0;
      flush_s     = 1'b0;
      clr_sh_s    = 1'b0;
      col_adv_s   = 1'b0;
      orow_adv_s  = 1'b0;
      orow_clr_s  = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (accept_s) begin
               col_adv_s  = 1'b1;
               state_nx_s = S_FILL;
            end else begin
               state_nx_s = S_IDLE;
            end
         end
         S_FILL: begin
            if (accept_s) begin
               col_adv_s = 1'b1;
               if (col_r == COL_ONE) begin
                  state_nx_s = S_STREAM;
`ifdef NIP_BORDER_ZERO_EN
                  // Column-0 window {0, p0, p1} is complete once column 1 arrives.
                  emit_s = 1'b1;
`endif
               end else begin
                  state_nx_s = S_FILL;
               end
            end else begin
               state_nx_s = S_FILL;
            end
         end
         S_STREAM: begin
            if (accept_s) begin
               col_adv_s = 1'b1;
               emit_s    = 1'b1;
               if (col_r == COL_LAST) begin
`ifdef NIP_BORDER_ZERO_EN
                  state_nx_s = S_FLUSH;
`else
                  row_end_s = 1'b1;
                  if (orow_r == ROW_LAST) begin
                     state_nx_s = S_DONE;
                  end else begin
                     orow_adv_s = 1'b1;
                     state_nx_s = S_FILL;
                  end
`endif
               end else begin
                  state_nx_s = S_STREAM;
               end
            end else begin
               state_nx_s = S_STREAM;
            end
         end
         S_FLUSH: begin
            // Shift in a zero column for the right-edge window, then clear for the next row.
            flush_s   = 1'b1;
            emit_s    = 1'b1;
            row_end_s = 1'b1;
            clr_sh_s  = 1'b1;
            if (orow_r == ROW_LAST) begin
               state_nx_s = S_DONE;
            end else begin
               orow_adv_s = 1'b1;
               state_nx_s = S_FILL;
            end
         end
         S_DONE: begin
            frame_end_s = 1'b1;
            orow_clr_s  = 1'b1;
            clr_sh_s    = 1'b1;
            state_nx_s  = S_IDLE;
         end
         default: begin
            state_nx_s = S_IDLE;
         end
      endcase
   end

   // Counters, shift register, sticky drop flag and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_r        <= {COL_W{1'b0}};
         orow_r       <= {ROW_W{1'b0}};
         sh_r         <= {WIN_W{1'b0}};
         win_r        <= {WIN_W{1'b0}};
         in_ready_r   <= 1'b0;
         win_valid_r  <= 1'b0;
         row_done_r   <= 1'b0;
         frame_done_r <= 1'b0;
         drop_err_r   <= 1'b0;
      end else if (start) begin
         col_r        <= {COL_W{1'b0}};
         orow_r       <= {ROW_W{1'b0}};
         sh_r         <= {WIN_W{1'b0}};
         win_r        <= {WIN_W{1'b0}};
         in_ready_r   <= 1'b1;
         win_valid_r  <= 1'b0;
         row_done_r   <= 1'b0;
         frame_done_r <= 1'b0;
         drop_err_r   <= 1'b0;
      end else begin
         if (clr_sh_s) begin
            sh_r <= {WIN_W{1'b0}};
         end else if (accept_s) begin
            sh_r <= sh_shift_s;
         end
         if (col_adv_s) begin
            col_r <= (col_r == COL_LAST) ? {COL_W{1'b0}} : col_r + COL_W'(1);
         end
         if (orow_clr_s) begin
            orow_r <= {ROW_W{1'b0}};
         end else if (orow_adv_s) begin
            orow_r <= orow_r + ROW_W'(1);
         end
         if (emit_s) begin
            win_r <= sh_shift_s;
         end
         win_valid_r  <= emit_s;
         row_done_r   <= row_end_s;
         frame_done_r <= frame_end_s;
         in_ready_r   <= (state_nx_s != S_FLUSH) && (state_nx_s != S_DONE);
         drop_err_r   <= drop_err_r | drop_s;
      end
   end

   assign bus.in_ready   = in_ready_r;
   assign bus.win        = win_r;
   assign bus.win_valid  = win_valid_r;
   assign bus.row_done   = row_done_r;
   assign bus.frame_done = frame_done_r;
   assign bus.drop_err   = drop_err_r;
endmodule

// File: tb/tb_nip_window_former.sv
// Bench for nip_window_former on an 8x5 frame (pixel = row*16+col); expected windows are
// queued as beats are driven and popped as the DUT emits them.
module tb_nip_window_former;
   localparam int PIX_W   = 8;
   localparam int IMG_W   = 8;
   localparam int IMG_H   = 5;
   localparam int NUM_RB  = 4;
   localparam int STEER_W = 2;
   localparam int WIN_W   = 9 * PIX_W;
   localparam int N_BEATS = IMG_W * (IMG_H - 2);
`ifdef NIP_BORDER_ZERO_EN
   localparam int EXP_WIN = IMG_W * (IMG_H - 2);
`else
   localparam int EXP_WIN = (IMG_W - 2) * (IMG_H - 2);
`endif

   typedef struct {
      logic [WIN_W-1:0] w;
      logic             last;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   logic clk = 1'b0;
   logic rst_n;
   logic start;
   int   n_cmp   = 0;
   int   n_err   = 0;
   int   win_cnt = 0;
   int   rd_cnt  = 0;
   int   fd_cnt  = 0;
   logic prev_wv = 1'b0;
   int   sent;

   nip_window_former_if #(.PIX_W(PIX_W), .NUM_RB(NUM_RB), .STEER_W(STEER_W)) bus ();

   nip_window_former #(
      .PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .NUM_RB(NUM_RB), .STEER_W(STEER_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [WIN_W-1:0] act,
                            input logic [WIN_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [PIX_W-1:0] pix(input int r, input int c);
      return PIX_W'(r * 16 + c);
   endfunction

   // Window centred on column cc of output row orow; off-image columns read as zero.
   function automatic logic [WIN_W-1:0] model_win(input int orow, input int cc);
      logic [WIN_W-1:0] w;
      int x;
      w = {WIN_W{1'b0}};
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            x = cc - 1 + c;
            if (x >= 0 && x < IMG_W) w[(r*3+c)*PIX_W +: PIX_W] = pix(orow + r, x);
         end
      end
      return w;
   endfunction

   task automatic set_beat(input int orow, input int col);
      int b;
      bus.steer = STEER_W'((orow + 3) % NUM_RB);
      for (int k = 0; k < NUM_RB; k++) begin
         b = (orow + k) % NUM_RB;
         bus.rb_data[b*PIX_W +: PIX_W] = (k == NUM_RB - 1) ? 8'hEE : pix(orow + k, col);
      end
      bus.steer_en = 1'b1;
   endtask

   task automatic push_expect(input int orow, input int col);
      exp_t e;
`ifdef NIP_BORDER_ZERO_EN
      if (col >= 1) begin
         e.w = model_win(orow, col - 1);
         e.last = 1'b0;
         exp_q.push_back(e);
      end
      if (col == IMG_W - 1) begin
         e.w = model_win(orow, IMG_W - 1);
         e.last = 1'b1;
         exp_q.push_back(e);
      end
`else
      if (col >= 2) begin
         e.w = model_win(orow, col - 1);
         e.last = (col == IMG_W - 1);
         exp_q.push_back(e);
      end
`endif
   endtask

   // Drives n beats in raster order, skipping cycles at random (gap_pct) or while not ready.
   task automatic drive_beats(input int gap_pct, input int n, output int n_sent);
      int guard;
      n_sent = 0;
      guard  = 0;
      while (n_sent < n && guard < 4000) begin
         @(negedge clk);
         guard++;
         if (bus.in_ready && ($urandom_range(99) >= gap_pct)) begin
            set_beat(n_sent / IMG_W, n_sent % IMG_W);
            push_expect(n_sent / IMG_W, n_sent % IMG_W);
            n_sent++;
         end else begin
            bus.steer_en = 1'b0;
         end
      end
      @(posedge clk);
      #1 bus.steer_en = 1'b0;
   endtask

   task automatic run_frame(input string tag, input int gap_pct, input logic poke);
      int w0, r0, f0;
      w0 = win_cnt;
      r0 = rd_cnt;
      f0 = fd_cnt;
      drive_beats(gap_pct, N_BEATS, sent);
      check_val({tag, "_beats"}, sent, N_BEATS);
      @(negedge clk);
      check_val({tag, "_in_ready_low"}, bus.in_ready, 1'b0);
      bus.steer_en = poke;
      @(negedge clk);
      bus.steer_en = 1'b0;
      check_val({tag, "_drop_err"}, bus.drop_err, poke);
      repeat (6) @(negedge clk);
      check_val({tag, "_win_count"}, win_cnt - w0, EXP_WIN);
      check_val({tag, "_row_done_count"}, rd_cnt - r0, IMG_H - 2);
      check_val({tag, "_frame_done_count"}, fd_cnt - f0, 1);
      check_val({tag, "_queue_empty"}, exp_q.size(), 0);
   endtask

   task automatic check_reset(input string tag);
      check_val({tag, "_win_valid"}, bus.win_valid, 1'b0);
      check_val({tag, "_win"}, bus.win, {WIN_W{1'b0}});
      check_val({tag, "_in_ready"}, bus.in_ready, 1'b0);
      check_val({tag, "_row_done"}, bus.row_done, 1'b0);
      check_val({tag, "_frame_done"}, bus.frame_done, 1'b0);
      check_val({tag, "_drop_err"}, bus.drop_err, 1'b0);
   endtask

   // Scoreboard: every emitted window is matched against the next queued expectation.
   always @(negedge clk) begin
      if (bus.win_valid) begin
         win_cnt <= win_cnt + 1;
         check_val("win_expected", (exp_q.size() > 0), 1'b1);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check_val("win", bus.win, mon_e.w);
            check_val("row_done", bus.row_done, mon_e.last);
         end
      end
      if (bus.frame_done) begin
         fd_cnt <= fd_cnt + 1;
         check_val("frame_done_after_win", prev_wv, 1'b1);
      end
      rd_cnt  <= rd_cnt + int'(bus.row_done);
      prev_wv <= bus.win_valid;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n        = 1'b0;
      start        = 1'b0;
      bus.steer_en = 1'b0;
      bus.steer    = {STEER_W{1'b0}};
      bus.rb_data  = {(NUM_RB*PIX_W){1'b0}};
      repeat (2) @(negedge clk);
      check_reset("por");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_val("in_ready_idle", bus.in_ready, 1'b1);

      run_frame("plain", 0, 1'b0);
      run_frame("gaps", 50, 1'b0);

      // Beat offered while not ready: dropped, flag sticks until start.
      run_frame("drop", 0, 1'b1);
      repeat (3) @(negedge clk);
      check_val("drop_err_held", bus.drop_err, 1'b1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_val("drop_err_cleared", bus.drop_err, 1'b0);

      // Reset in the middle of the second output row, then replay the frame.
      drive_beats(0, IMG_W + 3, sent);
      repeat (3) @(negedge clk);
      check_val("mid_queue_drained", exp_q.size(), 0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      check_reset("mid_rst");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      run_frame("after_rst", 0, 1'b0);

      // start together with a valid beat while streaming: the beat must be ignored.
      drive_beats(0, 4, sent);
      @(negedge clk);
      set_beat(0, 4);
      start = 1'b1;
      @(negedge clk);
      start        = 1'b0;
      bus.steer_en = 1'b0;
      check_val("start_no_win", bus.win_valid, 1'b0);
      check_val("start_in_ready", bus.in_ready, 1'b1);
      check_val("start_queue_empty", exp_q.size(), 0);
      run_frame("after_start", 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
